my_reg_pipe: RTL and testbench
==============================

Name: my_reg_pipe

Overview:
- Parametrised successor to the single-register primitive.
- A DEPTH-stage register pipeline of DATA_W-bit words with per-stage valid bits and valid/ready backpressure.
- Bubbles collapse: a stalled output does not block upstream stages that hold empty slots.
- Adds a clock enable, a synchronous flush and an occupancy count. Used to retime long datapaths between blocks that already speak valid/ready.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- DEPTH, 2, number of register stages (>=1).
- RST_VAL, {DATA_W{1'b0}}, value loaded into every data stage on reset.

Ports:
- clk_i  input  1  clock, all state updates on posedge.
- rst_i  input  1  reset; synchronous, active-high.
- en_i  input  1  clock enable; 0 freezes all state and blocks both handshakes.
- flush_i  input  1  synchronous flush; empties every stage.
- in_valid_i  input  1  upstream word valid.
- in_ready_o  output  1  pipeline accepts a word this cycle.
- in_data_i  input  DATA_W  upstream word.
- out_valid_o  output  1  last stage holds a word.
- out_ready_i  input  1  downstream accepts the word.
- out_data_o  output  DATA_W  word in the last stage.
- count_o  output  $clog2(DEPTH+1)  number of occupied stages, 0..DEPTH.

Behaviour:
- Stages are indexed 0 (input side) to DEPTH-1 (output). Each stage k holds valid_k and data_k.
- Reset (rst_i=1 at posedge): all valid_k=0 and all data_k=RST_VAL.
  - After reset: out_valid_o=0, out_data_o=RST_VAL, count_o=0, in_ready_o=en_i.
- Priority at each posedge: rst_i > flush_i > en_i=0 (hold) > normal operation.
- Ready chain (combinational):
  - rdy_DEPTH = out_ready_i.
  - rdy_k = !valid_k || rdy_{k+1}.
  - in_ready_o = en_i && !flush_i && rdy_0.
  - out_valid_o = en_i && !flush_i && valid_{DEPTH-1}.
  - There is a combinational path from out_ready_i to in_ready_o; this is intended.
- Transfers: input transfer = in_valid_i && in_ready_o; output transfer = out_valid_o && out_ready_i.
- Normal update, when en_i=1 and flush_i=0, for each stage k where rdy_k=1:
  - valid_k <= src_valid.
  - data_k <= src_data only if src_valid=1; otherwise data_k holds its old value.
  - src is stage k-1, or the input port for k=0.
  - When stage k-1 hands off to stage k and receives nothing itself, valid_{k-1} clears.
- Latency: a word accepted at cycle t appears on out_valid_o at cycle t+DEPTH when there is no stall. Throughput is 1 word/cycle with out_ready_i held at 1.
- Full pipeline (count_o=DEPTH) with out_ready_i=1: input and output transfers occur in the same cycle and count_o is unchanged.
- Full pipeline with out_ready_i=0: in_ready_o=0.
- Empty pipeline: out_valid_o=0, and out_data_o shows the last retained value of data_{DEPTH-1}.
- count_o is the registered population count of the valid_k bits. Next-cycle delta = +input transfer − output transfer.
- en_i=0: every register holds, in_ready_o=0, out_valid_o=0, no transfers occur. count_o and out_data_o are unchanged.
- flush_i=1: all valid_k <= 0 and data_k hold. No handshake completes in the flush cycle (in_ready_o=0, out_valid_o=0). flush_i takes effect regardless of en_i.
- rst_i asserted mid-stream: words in flight are discarded without any output transfer, and the post-reset values above apply on the next cycle.
- DEPTH=1: the block degenerates to a single registered slot with ready = !valid || out_ready_i, so full throughput is still sustained.
- Data registers load only on an accepted transfer. No X propagates from in_data_i when in_valid_i=0.

Test Plan:
- DATA_W=8, DEPTH=3, rst_i pulse -> out_valid_o=0, out_data_o=8'h00, count_o=0, in_ready_o=1.
- Stream 0x11,0x22,0x33,0x44 on consecutive cycles, out_ready_i=1 -> 0x11 appears on out_valid_o 3 cycles after acceptance, then 1 word/cycle in order; count_o peaks at 3.
- Fill with 0xA1,0xA2,0xA3 while out_ready_i=0 -> count_o=3, in_ready_o=0, out_data_o=0xA1. Raise out_ready_i for 1 cycle with in_valid_i=1 and data 0xA4 -> 0xA1 is consumed, 0xA4 is accepted, count_o stays 3.
- Bubble collapse: load one word 0x5C, hold out_ready_i=0 for 5 cycles, then send 0x6D -> 0x5C reaches stage 2 and 0x6D advances to stage 1 behind it; count_o=2, in_ready_o=1.
- Three words in flight, en_i=0 for 4 cycles with in_valid_i=1 and out_ready_i=1 -> no transfers, count_o is constant, the output order is unchanged after en_i returns to 1.
- Three words in flight, assert flush_i for 1 cycle -> the next cycle shows count_o=0 and out_valid_o=0 with no output transfer in the flush cycle. A simultaneous rst_i+flush_i -> data=RST_VAL.

Source files
------------

// File: rtl/my_reg_pipe_if.sv
// rtl/my_reg_pipe_if.sv - valid/ready input and output streams of the register pipeline
interface my_reg_pipe_if #(
  parameter int DATA_W = 8
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;

  // The environment around the pipeline drives the upstream word and the downstream ready.
  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o
  );

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o
  );
endinterface

// File: rtl/my_reg_pipe.sv
// rtl/my_reg_pipe.sv - DEPTH-stage valid/ready register pipeline with bubble collapse, enable, flush and occupancy count
module my_reg_pipe #(
  parameter int                 DATA_W  = 8,
  parameter int                 DEPTH   = 2,
  parameter logic [DATA_W-1:0]  RST_VAL = {DATA_W{1'b0}},
  localparam int                CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             flush_i,
  my_reg_pipe_if.slave     bus,
  output logic [CNT_W-1:0] count_o
);

  logic [DEPTH-1:0]  valid_q;
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [DEPTH-1:0]  rdy;
  logic [DEPTH-1:0]  src_valid;
  logic [DATA_W-1:0] src_data [DEPTH];
  logic              active;
  logic              in_xfer;
  logic              out_xfer;

  // The ready chain is walked with a running variable so the vector never feeds itself.
  always_comb begin
    logic r;
    r   = bus.out_ready_i;
    rdy = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      r      = !valid_q[k] || r;
      rdy[k] = r;
    end
  end

  always_comb begin
    src_valid    = '0;
    src_valid[0] = bus.in_valid_i;
    src_data[0]  = bus.in_data_i;
    for (int k = 1; k < DEPTH; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
    end
  end

  assign active          = en_i && !flush_i;
  assign bus.in_ready_o  = active && rdy[0];
  assign bus.out_valid_o = active && valid_q[DEPTH-1];
  assign bus.out_data_o  = data_q[DEPTH-1];
  assign in_xfer         = bus.in_valid_i && bus.in_ready_o;
  assign out_xfer        = bus.out_valid_o && bus.out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      count_o <= '0;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= RST_VAL;
    end else if (flush_i) begin
      valid_q <= '0;
      count_o <= '0;
    end else if (en_i) begin
      // A stage with rdy set either passes its word on or is empty, so it may take its source.
      for (int k = 0; k < DEPTH; k++) begin
        if (rdy[k]) begin
          valid_q[k] <= src_valid[k];
          if (src_valid[k]) data_q[k] <= src_data[k];
        end
      end
      count_o <= count_o + CNT_W'(in_xfer) - CNT_W'(out_xfer);
    end
  end

endmodule

// File: tb/tb_my_reg_pipe.sv
// tb/tb_my_reg_pipe.sv - directed self-checking bench for my_reg_pipe with DEPTH=3, DATA_W=8
module tb_my_reg_pipe;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       flush = 1'b0;
  logic [1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  my_reg_pipe_if #(.DATA_W(DATA_W)) bus ();

  my_reg_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RST_VAL(8'h00)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (en),
    .flush_i (flush),
    .bus     (bus.slave),
    .count_o (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] s_iv [7] = '{1, 1, 1, 1, 0, 0, 0};
  logic [7:0] s_id [7] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00};
  logic [7:0] s_cnt[7] = '{1, 2, 3, 3, 2, 1, 0};
  logic [7:0] s_ov [7] = '{0, 0, 1, 1, 1, 1, 0};
  logic [7:0] s_od [7] = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};

  initial begin
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = 8'h00;
    bus.out_ready_i = 1'b1;

    // reset
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_out_data", bus.out_data_o, 8'h00);
    chk("rst_count", count, 0);
    chk("rst_in_ready", bus.in_ready_o, 1);

    // streaming, out_ready held high
    for (int i = 0; i < 7; i++) begin
      bus.in_valid_i = s_iv[i][0];
      bus.in_data_i  = s_id[i];
      #1;
      if (s_iv[i][0]) chk($sformatf("stream_in_ready_%0d", i), bus.in_ready_o, 1);
      tick();
      chk($sformatf("stream_count_%0d", i), count, s_cnt[i]);
      chk($sformatf("stream_out_valid_%0d", i), bus.out_valid_o, s_ov[i]);
      chk($sformatf("stream_out_data_%0d", i), bus.out_data_o, s_od[i]);
    end
    bus.in_valid_i = 1'b0;

    // fill against backpressure, then one simultaneous in/out transfer
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.in_data_i = 8'hA1; tick();
    bus.in_data_i = 8'hA2; tick();
    bus.in_data_i = 8'hA3; tick();
    bus.in_valid_i = 1'b0;
    #1;
    chk("full_count", count, 3);
    chk("full_in_ready", bus.in_ready_o, 0);
    chk("full_out_data", bus.out_data_o, 8'hA1);
    chk("full_out_valid", bus.out_valid_o, 1);
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.in_data_i   = 8'hA4;
    #1;
    chk("full_in_ready_when_out_ready", bus.in_ready_o, 1);
    tick();
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b0;
    chk("swap_count", count, 3);
    chk("swap_out_data", bus.out_data_o, 8'hA2);
    bus.out_ready_i = 1'b1;
    tick();
    chk("drain_a3", bus.out_data_o, 8'hA3);
    tick();
    chk("drain_a4", bus.out_data_o, 8'hA4);
    tick();
    chk("drain_count", count, 0);
    chk("drain_out_valid", bus.out_valid_o, 0);

    // bubble collapse
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.in_data_i   = 8'h5C;
    tick();
    bus.in_valid_i = 1'b0;
    repeat (4) tick();
    chk("bubble_out_valid", bus.out_valid_o, 1);
    chk("bubble_out_data", bus.out_data_o, 8'h5C);
    chk("bubble_count1", count, 1);
    chk("bubble_in_ready1", bus.in_ready_o, 1);
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = 8'h6D;
    tick();
    bus.in_valid_i = 1'b0;
    tick();
    chk("bubble_count2", count, 2);
    chk("bubble_in_ready2", bus.in_ready_o, 1);
    chk("bubble_head", bus.out_data_o, 8'h5C);
    bus.out_ready_i = 1'b1;
    tick();
    chk("bubble_second_at_out", bus.out_data_o, 8'h6D);
    chk("bubble_second_valid", bus.out_valid_o, 1);
    chk("bubble_count3", count, 1);
    tick();
    chk("bubble_empty", count, 0);

    // clock enable freeze
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.in_data_i = 8'hB1; tick();
    bus.in_data_i = 8'hB2; tick();
    bus.in_data_i = 8'hB3; tick();
    en = 1'b0;
    bus.in_data_i   = 8'hC0;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("en0_in_ready_%0d", i), bus.in_ready_o, 0);
      chk($sformatf("en0_out_valid_%0d", i), bus.out_valid_o, 0);
      chk($sformatf("en0_count_%0d", i), count, 3);
      chk($sformatf("en0_out_data_%0d", i), bus.out_data_o, 8'hB1);
      tick();
    end
    en = 1'b1;
    bus.in_valid_i = 1'b0;
    #1;
    chk("en1_out_valid", bus.out_valid_o, 1);
    chk("en1_b1", bus.out_data_o, 8'hB1);
    tick();
    chk("en1_b2", bus.out_data_o, 8'hB2);
    tick();
    chk("en1_b3", bus.out_data_o, 8'hB3);
    tick();
    chk("en1_count", count, 0);

    // flush
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    bus.in_data_i = 8'hD1; tick();
    bus.in_data_i = 8'hD2; tick();
    bus.in_data_i = 8'hD3; tick();
    flush = 1'b1;
    bus.out_ready_i = 1'b1;
    bus.in_data_i   = 8'hEE;
    #1;
    chk("flush_in_ready", bus.in_ready_o, 0);
    chk("flush_out_valid", bus.out_valid_o, 0);
    tick();
    flush = 1'b0;
    bus.in_valid_i = 1'b0;
    #1;
    chk("post_flush_count", count, 0);
    chk("post_flush_out_valid", bus.out_valid_o, 0);
    chk("post_flush_data_held", bus.out_data_o, 8'hD1);

    // reset wins over flush and restores data
    rst = 1'b1;
    flush = 1'b1;
    tick();
    rst = 1'b0;
    flush = 1'b0;
    #1;
    chk("rst_flush_out_data", bus.out_data_o, 8'h00);
    chk("rst_flush_count", count, 0);
    chk("rst_flush_in_ready", bus.in_ready_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
